// File: rtl/fpu_round_pack_pipe.sv
// fpu_round_pack_pipe
//   Two-stage pipelined IEEE-754 round-and-pack unit. Takes a pre-rounding
//   {sign, exponent, fraction, G/R/S} result plus a one-hot type. It applies
//   the selected rounding mode and packs one result per cycle, together with
//   the zero/overflow/underflow/infinity/NaN/inexact flags.
//   Stage 1 decodes the type and computes the round increment and inexact.
//   Stage 2 adds the increment, normalises, saturates and packs.
// Ports
//   fpu_clk, fpu_rst        clock, asynchronous active-high reset
//   in_valid/in_ready       input handshake (in_ready is combinational)
//   in_sign/exp/exp_ovf/frac/grs/type/rm/tag   input beat payload
//   out_valid/out_ready     output handshake with full backpressure
//   out_result, out_tag     packed result and its pass-through tag
//   out_zf/ovf/uf/inf/nanf/nxf  exception flags, registered with out_result
module fpu_round_pack_pipe #(
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned FRACTION_WIDTH = 23,
  parameter int unsigned OPERAND_WIDTH  = 1 + EXPONENT_WIDTH + FRACTION_WIDTH,
  parameter int unsigned TAG_WIDTH      = 4
) (
  input  logic                      fpu_clk,
  input  logic                      fpu_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXPONENT_WIDTH-1:0] in_exp,
  input  logic                      in_exp_ovf,
  input  logic [FRACTION_WIDTH-1:0] in_frac,
  input  logic [2:0]                in_grs,
  input  logic [4:0]                in_type,
  input  logic [2:0]                in_rm,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_WIDTH-1:0]  out_result,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      out_zf,
  output logic                      out_ovf,
  output logic                      out_uf,
  output logic                      out_inf,
  output logic                      out_nanf,
  output logic                      out_nxf
);

  localparam int unsigned EW = EXPONENT_WIDTH;
  localparam int unsigned FW = FRACTION_WIDTH;
  localparam int unsigned PW = 1 + EW + FW;

  localparam logic [EW-1:0] EXP_ONES  = '1;
  localparam logic [EW-1:0] EXP_MAXF  = EXP_ONES - EW'(1);
  localparam logic [FW-1:0] FRAC_ONES = '1;
  localparam logic [FW-1:0] QNAN_FRAC = FW'(1) << (FW - 1);

  typedef enum logic [1:0] {
    KIND_FINITE = 2'd0,
    KIND_INF    = 2'd1,
    KIND_NAN    = 2'd2
  } kind_e;

  // Handshake: a stage moves when it is empty or its successor is moving.
  logic s1_valid;
  logic s1_advance;
  logic s2_advance;

  assign s2_advance = !out_valid | out_ready;
  assign s1_advance = !s1_valid | s2_advance;
  assign in_ready   = s1_advance;

  // Stage 1 combinational: type decode, round increment, inexact.
  logic  g_bit, r_bit, s_bit, any_grs;
  logic  inc_d, to_inf_d, sign_d, nxf_d;
  kind_e kind_d;

  assign {g_bit, r_bit, s_bit} = in_grs;
  assign any_grs = |in_grs;

  always_comb begin
    inc_d    = g_bit & (r_bit | s_bit | in_frac[0]);
    to_inf_d = 1'b1;
    case (in_rm)
      3'b001: begin
        inc_d    = 1'b0;
        to_inf_d = 1'b0;
      end
      3'b010: begin
        inc_d    = in_sign & any_grs;
        to_inf_d = in_sign;
      end
      3'b011: begin
        inc_d    = !in_sign & any_grs;
        to_inf_d = !in_sign;
      end
      3'b100: begin
        inc_d    = g_bit;
        to_inf_d = 1'b1;
      end
      default: ;
    endcase

    kind_d = KIND_FINITE;
    sign_d = in_sign;
    if (in_type[4] | in_type[1]) begin
      kind_d = KIND_NAN;
    end else if (in_type[3]) begin
      kind_d = KIND_INF;
      sign_d = 1'b0;
    end else if (in_type[2]) begin
      kind_d = KIND_INF;
      sign_d = 1'b1;
    end else if (!in_type[0]) begin
      kind_d = KIND_NAN;
    end
    nxf_d = any_grs & (kind_d == KIND_FINITE);
  end

  // Stage 1 registers
  logic          s1_sign, s1_exp_ovf, s1_inc, s1_nxf, s1_to_inf;
  logic [EW-1:0] s1_exp;
  logic [FW-1:0] s1_frac;
  logic [TAG_WIDTH-1:0] s1_tag;
  kind_e         s1_kind;

  always_ff @(posedge fpu_clk or posedge fpu_rst) begin
    if (fpu_rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp_ovf <= 1'b0;
      s1_inc     <= 1'b0;
      s1_nxf     <= 1'b0;
      s1_to_inf  <= 1'b0;
      s1_exp     <= '0;
      s1_frac    <= '0;
      s1_tag     <= '0;
      s1_kind    <= KIND_FINITE;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= sign_d;
        s1_exp_ovf <= in_exp_ovf;
        s1_inc     <= inc_d;
        s1_nxf     <= nxf_d;
        s1_to_inf  <= to_inf_d;
        s1_exp     <= in_exp;
        s1_frac    <= in_frac;
        s1_tag     <= in_tag;
        s1_kind    <= kind_d;
      end
    end
  end

  // Stage 2 combinational: add increment, normalise, saturate, pack.
  logic [FW:0]   frac_sum;
  logic [EW:0]   exp_rnd;
  logic          ovf_hit, at_max;
  logic [PW-1:0] nxt_result;
  logic          nxt_zf, nxt_ovf, nxt_uf, nxt_inf, nxt_nanf, nxt_nxf;

  always_comb begin
    frac_sum = {1'b0, s1_frac} + {{FW{1'b0}}, s1_inc};
    // A carry out leaves the fraction at zero; from exp 0 it lands on exp 1.
    exp_rnd  = {1'b0, s1_exp} + {{EW{1'b0}}, frac_sum[FW]};
    at_max   = (s1_exp == EXP_MAXF) & (&s1_frac);
    // In truncating modes a value above max finite never carries, so the
    // overflow is judged on the unrounded magnitude there.
    ovf_hit  = s1_exp_ovf | (exp_rnd >= {1'b0, EXP_ONES}) |
               (at_max & s1_nxf & !s1_to_inf);

    nxt_result = '0;
    nxt_zf     = 1'b0;
    nxt_ovf    = 1'b0;
    nxt_uf     = 1'b0;
    nxt_inf    = 1'b0;
    nxt_nanf   = 1'b0;
    nxt_nxf    = 1'b0;

    case (s1_kind)
      KIND_NAN: begin
        nxt_result = {1'b0, EXP_ONES, QNAN_FRAC};
        nxt_nanf   = 1'b1;
      end
      KIND_INF: begin
        nxt_result = {s1_sign, EXP_ONES, {FW{1'b0}}};
        nxt_inf    = 1'b1;
      end
      default: begin
        if (ovf_hit) begin
          nxt_ovf = 1'b1;
          nxt_nxf = 1'b1;
          if (s1_to_inf) begin
            nxt_result = {s1_sign, EXP_ONES, {FW{1'b0}}};
            nxt_inf    = 1'b1;
          end else begin
            nxt_result = {s1_sign, EXP_MAXF, FRAC_ONES};
          end
        end else begin
          nxt_result = {s1_sign, exp_rnd[EW-1:0], frac_sum[FW-1:0]};
          nxt_nxf    = s1_nxf;
          nxt_uf     = (exp_rnd == '0) & s1_nxf;
          nxt_zf     = (exp_rnd == '0) & (frac_sum[FW-1:0] == '0);
        end
      end
    endcase
  end

  // Stage 2 registers: result and flags only change when a new beat loads.
  always_ff @(posedge fpu_clk or posedge fpu_rst) begin
    if (fpu_rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_zf     <= 1'b0;
      out_ovf    <= 1'b0;
      out_uf     <= 1'b0;
      out_inf    <= 1'b0;
      out_nanf   <= 1'b0;
      out_nxf    <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= OPERAND_WIDTH'(nxt_result);
        out_tag    <= s1_tag;
        out_zf     <= nxt_zf;
        out_ovf    <= nxt_ovf;
        out_uf     <= nxt_uf;
        out_inf    <= nxt_inf;
        out_nanf   <= nxt_nanf;
        out_nxf    <= nxt_nxf;
      end
    end
  end

endmodule
